// File: rtl/dmem_if.sv
// Load/store request/response handshake between the memory pipeline stage
// (master) and a data-memory responder (slave).
interface dmem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_wstrb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with fixed wait states, byte-masked
// stores and error responses for misaligned or out-of-range addresses.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);
  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [3:0]            lat_wstrb;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_error_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [3:0]            op_wstrb;
  logic                  op_err;
  logic [IDX_W-1:0]      op_idx;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

  assign accept     = bus.req_valid && bus.req_ready;
  assign enter_resp = !rst && (((WS == 4'd0) && accept) ||
                               ((state == WAIT) && (wait_cnt == 4'd1)));

  // With zero wait states the access happens on the accept edge itself, so the
  // operands come straight from the bus; otherwise from the latched request.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    op_write = lat_write;
    op_addr  = lat_addr;
    op_wdata = lat_wdata;
    op_wstrb = lat_wstrb;
    if (state == IDLE) begin
      op_write = bus.req_write;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
      op_wstrb = bus.req_wstrb;
    end
  end

  assign op_err = (op_addr[1:0] != 2'b00) ||
                  (op_addr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH));
  assign op_idx = op_addr[IDX_W+1:2];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_wstrb   <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_wstrb <= bus.req_wstrb;
            wait_cnt  <= WS;
            state     <= (WS == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_error_q <= op_err;
        rsp_rdata_q <= (op_err || op_write) ? '0 : mem[op_idx];
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; only the commit is gated by rst.
  always_ff @(posedge clk) begin
    if (enter_resp && op_write && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (op_wstrb[b]) mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with two wait states, one with none
// (back-to-back loads and stores with rsp_ready tied high).
module tb_dmem_responder;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_a ();
  dmem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_b ();

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(2))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One request on bus_a; lat = number of edges after the accept edge until
  // the first edge at which rsp_valid is seen high.
  task automatic xact_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic rdy,
                        output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    bus_a.req_valid = 1'b1;
    bus_a.req_write = wr;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    bus_a.req_wstrb = strb;
    bus_a.rsp_ready = rdy;
    while (!bus_a.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 32'(bus_a.req_ready), 32'd1);
    @(posedge clk);
    #1 bus_a.req_valid = 1'b0;
    lat = 0; rdata = '0; err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus_a.rsp_valid) begin
        lat = k; rdata = bus_a.rsp_rdata; err = bus_a.rsp_error;
        break;
      end
    end
    check("rsp_seen", 32'(bus_a.rsp_valid), 32'd1);
    if (rdy) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          seen;

  logic        b_wr   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] b_addr [5] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h6};
  logic [31:0] b_wdat [5] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 32'h0, 32'h0};
  logic [31:0] b_exp  [5] = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0};
  logic        b_err  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int          acc_cyc[5];
  int          rsp_cyc[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ai, ri;
    logic do_acc, do_rsp;
    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0;
    bus_a.req_wdata = '0;   bus_a.req_wstrb = 4'h0; bus_a.rsp_ready = 1'b1;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0;
    bus_b.req_wdata = '0;   bus_b.req_wstrb = 4'h0; bus_b.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(bus_a.rsp_error), 32'd0);
    check("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
    check("rst_req_ready_b", 32'(bus_b.req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(bus_a.req_ready), 32'd1);

    // Full store, then load back; latency 1+WAIT_STATES
    xact_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, rd, er, lat);
    check("st_lat", lat, 32'd3);
    check("st_err", 32'(er), 32'd0);
    check("st_rdata", rd, 32'd0);
    xact_a(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, lat);
    check("ld_lat", lat, 32'd3);
    check("ld_rdata", rd, 32'hDEADBEEF);

    // Byte-masked store and an empty-mask store
    xact_a(1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b1, rd, er, lat);
    xact_a(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, lat);
    check("mask_rdata", rd, 32'hDE22BE44);
    xact_a(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1, rd, er, lat);
    check("nostrb_err", 32'(er), 32'd0);
    xact_a(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, lat);
    check("nostrb_rdata", rd, 32'hDE22BE44);

    // Error responses
    xact_a(1'b0, 32'h12, 32'h0, 4'h0, 1'b1, rd, er, lat);
    check("mis_err", 32'(er), 32'd1);
    check("mis_rdata", rd, 32'd0);
    xact_a(1'b1, 32'(4*(DEPTH-1)), 32'h600DF00D, 4'hF, 1'b1, rd, er, lat);
    check("last_st_err", 32'(er), 32'd0);
    xact_a(1'b1, 32'(4*DEPTH), 32'hFFFFFFFF, 4'hF, 1'b1, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);
    xact_a(1'b0, 32'(4*(DEPTH-1)), 32'h0, 4'h0, 1'b1, rd, er, lat);
    check("last_word", rd, 32'h600DF00D);

    // Backpressure; a store presented meanwhile must be ignored
    xact_a(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
    check("bp_rdata", rd, 32'hDE22BE44);
    bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1;
    bus_a.req_addr  = 32'h10; bus_a.req_wdata = 32'h0; bus_a.req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus_a.rsp_valid), 32'd1);
      check("bp_hold", bus_a.rsp_rdata, 32'hDE22BE44);
      check("bp_ready", 32'(bus_a.req_ready), 32'd0);
    end
    bus_a.req_valid = 1'b0;
    bus_a.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_done_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("bp_done_ready", 32'(bus_a.req_ready), 32'd1);
    check("bp_rdata_kept", bus_a.rsp_rdata, 32'hDE22BE44);
    xact_a(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, lat);
    check("bp_ignored_st", rd, 32'hDE22BE44);

    // Reset mid-WAIT abandons the pending store
    xact_a(1'b1, 32'h20, 32'h01234567, 4'hF, 1'b1, rd, er, lat);
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1;
    bus_a.req_addr  = 32'h20; bus_a.req_wdata = 32'hCAFEF00D; bus_a.req_wstrb = 4'hF;
    check("rw_accept_ready", 32'(bus_a.req_ready), 32'd1);
    @(posedge clk);
    #1 bus_a.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check("rw_rst_ready", 32'(bus_a.req_ready), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_a.rsp_valid) seen++;
    end
    check("rw_no_rsp", seen, 32'd0);
    check("rw_rdata_rst", bus_a.rsp_rdata, 32'd0);
    xact_a(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, rd, er, lat);
    check("rw_old_value", rd, 32'h01234567);

    // Zero wait states, back-to-back traffic
    ai = 0; ri = 0;
    @(posedge clk);
    #1;
    bus_b.req_valid = 1'b1;       bus_b.req_write = b_wr[0];
    bus_b.req_addr  = b_addr[0];  bus_b.req_wdata = b_wdat[0]; bus_b.req_wstrb = 4'hF;
    for (int c = 0; c < 60 && ri < 5; c++) begin
      @(negedge clk);
      do_acc = bus_b.req_valid && bus_b.req_ready;
      do_rsp = bus_b.rsp_valid;
      if (do_rsp) begin
        check($sformatf("b%0d_rdata", ri), bus_b.rsp_rdata, b_exp[ri]);
        check($sformatf("b%0d_err", ri), 32'(bus_b.rsp_error), 32'(b_err[ri]));
        rsp_cyc[ri] = cyc;
        ri++;
      end
      if (do_acc) begin
        acc_cyc[ai] = cyc;
        ai++;
      end
      @(posedge clk);
      #1;
      if (do_acc) begin
        if (ai < 5) begin
          bus_b.req_write = b_wr[ai];   bus_b.req_addr = b_addr[ai];
          bus_b.req_wdata = b_wdat[ai];
        end else begin
          bus_b.req_valid = 1'b0;
        end
      end
    end
    check("b_rsp_count", ri, 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < ri) check($sformatf("b%0d_latency", i), rsp_cyc[i] - acc_cyc[i], 32'd1);
      if (i > 0 && i < ai) check($sformatf("b%0d_spacing", i), acc_cyc[i] - acc_cyc[i-1], 32'd2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
